mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Multi-cycle integer multiply/divide unit for the MIPS datapath; owns the architectural HI/LO registers.
- Sits on the consumer side of the ALU operand-select stage: takes the same selected operand pair (rs value, rt value) and returns results through HI/LO to the writeback path for MFHI/MFLO.
- Iterative radix-2 implementation, one bit per cycle; the pipeline stalls on `busy`.

Parameters:
- WIDTH, 32: operand and HI/LO width; equals `WORD_SIZE.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when busy=0
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op
- src_a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
- src_b  input  WIDTH  rt operand (multiplier / divisor)
- cancel  input  1  abort the in-flight operation (exception flush)
- busy  output  1  iteration in progress; pipeline must stall MULT/DIV/MFHI/MFLO
- done  output  1  one-cycle pulse, HI/LO updated by a MULT/DIV this cycle
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: on a clock edge with rst_n=0, hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0. Reset mid-operation discards the operation.
- FSM states: IDLE, RUN, FIX.
- IDLE: at edge N with start=1:
  - MULT/MULTU/DIV/DIVU: latch magnitudes and result signs, clear the partial accumulator, load counter=WIDTH, go to RUN. busy=1 from N+1.
  - MTHI/MTLO: write src_a into hi/lo at edge N. Stay IDLE. No busy, no done.
  - Undefined op: ignored.
- RUN: one iteration per cycle, counter decrements, WIDTH cycles in total.
  - Multiply: shift-add on a 2*WIDTH product.
  - Divide: restoring, one quotient bit per cycle.
  - When counter reaches 0, go to FIX.
- FIX (1 cycle):
  - Apply sign correction for signed ops.
  - Write hi/lo at the FIX edge. done=1 and busy=0 during the following cycle. Return to IDLE.
- Latency: start at edge N, hi/lo valid and done=1 after edge N+WIDTH+1 (N+33 at default). busy is high for exactly WIDTH+1 cycles.
- start while busy=1: ignored, with no queuing. The pipeline is responsible for holding the request.
- cancel=1 while busy: return to IDLE at the next edge. busy=0, no done, hi/lo unchanged. cancel in IDLE: no effect. Simultaneous cancel and start in IDLE: start is accepted.
- Multiply results:
  - {hi,lo} = full 2*WIDTH product.
  - MULT treats operands as two's complement; MULTU as unsigned.
- Divide results:
  - lo = quotient, truncated toward zero.
  - hi = remainder; its sign follows the dividend; |rem| < |divisor|.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
  - Divisor 0, signed or unsigned: lo=all ones, hi=src_a. Full latency is still taken.
- Operand registers are captured at start. src_a/src_b changes during RUN have no effect.
- done is never asserted for MTHI/MTLO, cancelled ops, or reset.

Test Plan:
- Reset then MULT src_a=0xFFFFFFFD (-3), src_b=7 -> busy 33 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT with the same operands -> hi=0, lo=1.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo update on each edge, busy and done stay 0. Then DIVU 17/5 with a second start pulsed at cycle 10 -> second start ignored, lo=3, hi=2.
- MULTU 5x6 with cancel at cycle 12 -> busy drops next cycle, no done, hi/lo keep prior values. A new MULTU 5x6 then yields lo=30, hi=0.
- rst_n=0 at cycle 20 of a DIV -> hi=lo=0, busy=0, done never pulses. The next operation completes normally.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// One product/quotient bit per cycle, followed by a single sign-fix cycle.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_acc;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_signed;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = ~op[0];
    assign w_is_div = op[1];
    assign w_a_neg  = w_signed & src_a[WIDTH-1];
    assign w_b_neg  = w_signed & src_b[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -src_a : src_a;
    assign w_abs_b  = w_b_neg ? -src_b : src_b;

    // Multiply step: add multiplicand into the upper half, shift product right.
    assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

    // Restoring divide step: remainder < divisor, so the difference fits WIDTH bits.
    assign w_trial = {r_acc, r_q[WIDTH-1]};
    assign w_ge    = (w_trial >= {1'b0, r_m});
    assign w_diff  = w_trial[WIDTH-1:0] - r_m;

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_div0 ? {WIDTH{1'b1}} : (r_neg_q ? -r_q : r_q);
    assign w_rem      = r_neg_r ? -r_acc : r_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_acc    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            r_state  <= S_RUN;
                            r_busy   <= 1'b1;
                            r_cnt    <= CNT_W'(WIDTH);
                            r_acc    <= '0;
                            r_is_div <= w_is_div;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_div0   <= w_is_div & (src_b == '0);
                            r_m      <= w_is_div ? w_abs_b : w_abs_a;
                            r_q      <= w_is_div ? w_abs_a : w_abs_b;
                        end else if (op == 3'b100) begin
                            r_hi <= src_a;
                        end else if (op == 3'b101) begin
                            r_lo <= src_a;
                        end
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_FIX;
                        end
                        if (r_is_div) begin
                            r_acc <= w_ge ? w_diff : w_trial[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], w_ge};
                        end else begin
                            r_acc <= w_sum[WIDTH:1];
                            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                        end
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!cancel) begin
                        r_done <= 1'b1;
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
